weight_fetch: RTL and testbench
===============================

WEIGHT_FETCH -- requirements
Module: weight_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one weight word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, weight memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge; one clock, reset asynchronous active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a fetch job.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first word address, sampled on accepted start.
REQ-007 SHALL have port length  input  ADDR_WIDTH+1  words to fetch (0..2^ADDR_WIDTH), sampled on accepted start.
REQ-008 SHALL have port mem_en  output  1  read enable to the memory read port.
REQ-009 SHALL have port mem_we  output  1  write enable, constant 0.
REQ-010 SHALL have port mem_addr  output  ADDR_WIDTH  memory read address.
REQ-011 SHALL have port mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after the mem_en cycle, held while mem_en low.
REQ-012 SHALL have port w_valid  output  1  weight stream valid.
REQ-013 SHALL have port w_ready  input  1  downstream ready.
REQ-014 SHALL have port w_data  output  DATA_WIDTH  weight word.
REQ-015 SHALL have port w_last  output  1  high with the final word of a job.
REQ-016 SHALL have port busy  output  1  high from accepted start until the done pulse.
REQ-017 SHALL have port done  output  1  one-cycle pulse when the job's last word has been transferred.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN, DONE.
REQ-019 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-020 SHALL on accepted start with length>0 load address counter = base_addr, issue counter = length, transfer counter = length, go to FETCH.
REQ-021 SHALL on accepted start with length=0 go to DONE without asserting mem_en or w_valid.
REQ-022 SHALL buffer returning words in a 2-entry output FIFO; a read is issued (mem_en=1) only if FIFO occupancy plus in-flight reads < 2 and issue counter > 0.
REQ-023 SHALL increment mem_addr after each issued read, wrapping modulo 2^ADDR_WIDTH (1023 -> 0 at default).
REQ-024 SHALL capture mem_rdata into the FIFO exactly one cycle after each issued read.
REQ-025 SHALL present the FIFO head on w_data with w_valid=1; a transfer occurs when w_valid and w_ready are both high.
REQ-026 SHALL hold w_data and w_valid stable while w_valid=1 and w_ready=0.
REQ-027 SHALL assert w_last only with the word for which transfer counter equals 1.
REQ-028 SHALL allow simultaneous FIFO push and pop in one cycle without loss or duplication.
REQ-029 SHALL sustain one transfer per cycle after first-word latency when w_ready stays high.
REQ-030 SHALL have first-word latency of 2 cycles: start at cycle 0, mem_en at cycle 1, w_valid at cycle 2.
REQ-031 SHALL move FETCH -> DRAIN when issue counter reaches 0, DRAIN -> DONE on the transfer of the w_last word, DONE -> IDLE after one cycle.
REQ-032 SHALL assert done only in DONE and busy in FETCH, DRAIN, DONE until the done cycle inclusive.
REQ-033 SHALL accept a new start in the cycle after done (back-to-back jobs).

Reset
REQ-034 SHALL on rst_n low immediately force state IDLE, FIFO empty, counters 0, and outputs mem_en=0, mem_we=0, mem_addr=0, w_valid=0, w_data=0, w_last=0, busy=0, done=0.
REQ-035 SHALL on reset mid-job abort the job with no further reads or transfers and no done pulse.
REQ-036 SHALL accept start on the first rising clk edge after rst_n deasserts.

Verification
REQ-037 SHALL cover: base_addr=0x010, length=4, w_ready=1 -> w_data = mem[0x10..0x13] on 4 consecutive cycles from cycle 2, w_last on 4th, done one cycle later.
REQ-038 SHALL cover: base_addr=0x3FE, length=4 -> mem_addr sequence 0x3FE,0x3FF,0x000,0x001, data in that order.
REQ-039 SHALL cover: length=8 with w_ready toggling 1,0,0,1 repeating -> exactly 8 transfers, in order, no duplicates, w_data stable during stalls, mem_en never asserted with FIFO+in-flight = 2.
REQ-040 SHALL cover: length=0 -> no mem_en, no w_valid, done pulse, busy high only until done.
REQ-041 SHALL cover: start pulsed again during FETCH of length=6 job -> ignored, exactly 6 words transferred.
REQ-042 SHALL cover: rst_n low after 3 of 10 words transferred -> all outputs 0 asynchronously, no done; new job after reset runs correctly.

Source files
------------

// File: rtl/weight_fetch.sv
// Streams a run of words from a synchronous-read weight memory into a
// valid/ready interface, keeping at most two words buffered or in flight.
module weight_fetch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_t;

  localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;
  localparam logic [ADDR_WIDTH:0]   CntOne  = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   issue_q, issue_d;
  logic [ADDR_WIDTH:0]   xfer_q, xfer_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] fifo0_q, fifo0_d, fifo1_q, fifo1_d;
  logic [1:0]            occ;
  logic                  pop;

  // A word returning from memory this cycle is presented directly when the
  // FIFO is empty, which gives the two-cycle first-word latency.
  assign occ      = cnt_q + {1'b0, inflight_q};
  assign mem_we   = 1'b0;
  assign mem_addr = addr_q;
  assign mem_en   = (state_q == StFetch) && (issue_q != '0) && (occ < 2'd2);
  assign w_valid  = (cnt_q != 2'd0) || inflight_q;
  assign w_data   = (cnt_q != 2'd0) ? fifo0_q : (inflight_q ? mem_rdata : '0);
  assign w_last   = w_valid && (xfer_q == CntOne);
  assign pop      = w_valid && w_ready;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issue_d    = issue_q;
    xfer_d     = xfer_q;
    cnt_d      = cnt_q;
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    inflight_d = mem_en;

    if (mem_en) begin
      addr_d  = addr_q + AddrOne;
      issue_d = issue_q - CntOne;
    end
    if (pop) begin
      xfer_d = xfer_q - CntOne;
    end

    // Push is the word arriving from memory; with an empty FIFO a push and
    // pop in the same cycle bypass storage entirely.
    case (cnt_q)
      2'd0: begin
        if (inflight_q && !pop) begin
          fifo0_d = mem_rdata;
          cnt_d   = 2'd1;
        end
      end
      2'd1: begin
        if (inflight_q && pop) begin
          fifo0_d = mem_rdata;
        end else if (inflight_q) begin
          fifo1_d = mem_rdata;
          cnt_d   = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          fifo0_d = fifo1_q;
          if (inflight_q) begin
            fifo1_d = mem_rdata;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      default: cnt_d = 2'd0;
    endcase

    case (state_q)
      StIdle: begin
        if (start) begin
          if (length == '0) begin
            state_d = StDone;
          end else begin
            addr_d  = base_addr;
            issue_d = length;
            xfer_d  = length;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (issue_d == '0) state_d = StDrain;
      end
      StDrain: begin
        if (pop && w_last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      issue_q    <= '0;
      xfer_q     <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      xfer_q     <= xfer_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
    end
  end

endmodule

// File: tb/tb_weight_fetch.sv
// Directed job table for weight_fetch with a synchronous-read memory model;
// every transfer, issued address and job boundary is checked.
module tb_weight_fetch;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          w_valid, w_last, busy, done;
  logic          w_ready = 1'b0;
  logic [DW-1:0] w_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [3:0]    rdy;          // w_ready for cycle c is rdy[c % 4]
    int            restart;      // cycle of an extra start pulse, 0 = none
    int            exp_done;     // expected done cycle, 0 = not checked
    int            abort_after;  // reset after this many transfers, 0 = none
  } vec_t;

  vec_t vecs[9];

  weight_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_last    (w_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] wfun(input logic [AW-1:0] a);
    return {12'hC0D, a, ~a};
  endfunction

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= wfun(mem_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_addr", {54'd0, mem_addr}, 64'd0);
    chk("rst_w_valid", {63'd0, w_valid}, 64'd0);
    chk("rst_w_data", {32'd0, w_data}, 64'd0);
    chk("rst_w_last", {63'd0, w_last}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
  endtask

  task automatic run_job(input vec_t v);
    int issued = 0;
    int xfers = 0;
    int last_xfer = -1;
    int first_v = -1;
    int first_en = -1;
    int len = int'(v.len);
    bit seen_done = 1'b0;
    bit stall = 1'b0;
    logic [DW-1:0] pdata = '0;
    logic plast = 1'b0;
    logic [AW-1:0] ea;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      start = (c == 0) || (v.restart != 0 && c == v.restart);
      base_addr = (c == 0) ? v.base : 10'h155;
      length = (c == 0) ? v.len : 11'd3;
      w_ready = v.rdy[c % 4];
      #1;
      chk("mem_we", {63'd0, mem_we}, 64'd0);
      if (c == 0) begin
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_done", {63'd0, done}, 64'd0);
        chk("idle_w_valid", {63'd0, w_valid}, 64'd0);
        chk("idle_mem_en", {63'd0, mem_en}, 64'd0);
      end else begin
        chk("busy", {63'd0, busy}, 64'd1);
      end
      if (mem_en) begin
        if (first_en < 0) first_en = c;
        ea = v.base + AW'(issued);
        chk("mem_addr", {54'd0, mem_addr}, {54'd0, ea});
        chk("issue_allowed", {63'd0, (issued < len) && (issued - xfers < 2)}, 64'd1);
        issued++;
      end
      if (stall) begin
        chk("stall_valid", {63'd0, w_valid}, 64'd1);
        chk("stall_data", {32'd0, w_data}, {32'd0, pdata});
        chk("stall_last", {63'd0, w_last}, {63'd0, plast});
      end
      if (w_valid) begin
        if (first_v < 0) first_v = c;
        chk("valid_in_range", {63'd0, xfers < len}, 64'd1);
      end
      if (w_valid && w_ready) begin
        ea = v.base + AW'(xfers);
        chk("w_data", {32'd0, w_data}, {32'd0, wfun(ea)});
        chk("w_last", {63'd0, w_last}, {63'd0, xfers == len - 1});
        xfers++;
        last_xfer = c;
      end
      stall = w_valid && !w_ready;
      pdata = w_data;
      plast = w_last;
      if (v.abort_after != 0 && xfers == v.abort_after) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        return;
      end
      if (done) begin
        seen_done = 1'b1;
        chk("xfer_count", 64'(xfers), 64'(len));
        chk("issue_count", 64'(issued), 64'(len));
        if (len > 0) chk("done_after_last", 64'(c), 64'(last_xfer + 1));
        if (v.exp_done != 0) chk("done_cycle", 64'(c), 64'(v.exp_done));
        if (v.exp_done != 0 && len > 0) begin
          chk("first_mem_en_cycle", 64'(first_en), 64'd1);
          chk("first_valid_cycle", 64'(first_v), 64'd2);
        end
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", {63'd0, seen_done}, 64'd1);
  endtask

  initial begin
    vecs[0] = '{10'h010, 11'd4,  4'b1111, 0, 6, 0};
    vecs[1] = '{10'h3FE, 11'd4,  4'b1111, 0, 6, 0};
    vecs[2] = '{10'h020, 11'd8,  4'b1001, 0, 0, 0};
    vecs[3] = '{10'h000, 11'd0,  4'b1111, 0, 1, 0};
    vecs[4] = '{10'h100, 11'd6,  4'b1111, 3, 8, 0};
    vecs[5] = '{10'h3FF, 11'd1,  4'b1111, 0, 3, 0};
    vecs[6] = '{10'h200, 11'd10, 4'b1111, 0, 0, 3};
    vecs[7] = '{10'h010, 11'd4,  4'b1111, 0, 6, 0};
    vecs[8] = '{10'h050, 11'd5,  4'b0110, 0, 0, 0};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs();

    for (int i = 0; i < 9; i++) begin
      run_job(vecs[i]);
      if (vecs[i].abort_after != 0) begin
        // Reset stays low across clock edges; nothing may restart or finish.
        repeat (2) begin
          @(negedge clk);
          #1;
          chk_reset_outputs();
        end
      end
    end

    @(negedge clk);
    #1;
    chk("final_done", {63'd0, done}, 64'd0);
    chk("final_busy", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
